// File: rtl/seq_normalizer_if.sv
// ---------------------------------------------------------------------------
// seq_normalizer_if
// Handshake/data bundle between a requester and the sequential normalizer.
//   start      : request strobe (requester -> normalizer)
//   A          : operand to normalize
//   Shift_mode : 1 = arithmetic, 0 = logical
//   right      : 1 = normalize rightwards, 0 = leftwards
//   M          : normalized operand (normalizer -> requester)
//   Cnt        : number of single-bit shifts applied
//   Zero       : captured operand was all zeros
//   busy       : operation in progress
//   done       : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface seq_normalizer_if #(
  parameter int BITS = 8
);
  logic            start;
  logic [BITS-1:0] A;
  logic            Shift_mode;
  logic            right;
  logic [BITS-1:0] M;
  logic [BITS-1:0] Cnt;
  logic            Zero;
  logic            busy;
  logic            done;

  modport master (
    output start, A, Shift_mode, right,
    input  M, Cnt, Zero, busy, done
  );

  modport slave (
    input  start, A, Shift_mode, right,
    output M, Cnt, Zero, busy, done
  );
endinterface

// File: rtl/seq_normalizer.sv
// ---------------------------------------------------------------------------
// seq_normalizer
// Iterative one-bit-per-cycle normalizer. An accepted start captures the
// operand and then shifts it left or right until the MSB pair (left) or LSB
// (right) reaches the normalized position, counting the shifts taken.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_normalizer_if slave modport (start/A/Shift_mode/right in,
//           M/Cnt/Zero/busy/done out)
// ---------------------------------------------------------------------------
module seq_normalizer #(
  parameter int BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_normalizer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [BITS-1:0] r_R;
  logic [BITS-1:0] r_M;
  logic [BITS-1:0] r_Cnt;
  logic            r_Zero;
  logic            r_mode;
  logic            r_right;

  logic            w_accept;
  logic            w_a_zero;
  logic            w_stop;

  // Left arithmetic stops once the two MSBs differ, i.e. the sign bit is the
  // only redundant-free bit left; left logical stops at a leading one.
  function automatic logic stop_cond(input logic [BITS-1:0] r,
                                     input logic            arith,
                                     input logic            rt);
    if (rt)
      return r[0];
    else if (arith)
      return r[BITS-1] ^ r[BITS-2];
    else
      return r[BITS-1];
  endfunction

  // Only the right arithmetic shift replicates the sign; every other
  // direction/mode fills with zero.
  function automatic logic [BITS-1:0] shift_one(input logic [BITS-1:0] r,
                                                input logic            arith,
                                                input logic            rt);
    if (rt)
      return {(arith & r[BITS-1]), r[BITS-1:1]};
    else
      return {r[BITS-2:0], 1'b0};
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_a_zero = (bus.A == '0);
  assign w_stop   = stop_cond(r_R, r_mode, r_right);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_a_zero ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_stop)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Any nonzero operand reaches its stop condition within BITS-1
  // shifts, so r_Cnt cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_R     <= '0;
      r_M     <= '0;
      r_Cnt   <= '0;
      r_Zero  <= 1'b0;
      r_mode  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_Cnt <= '0;
            if (w_a_zero) begin
              r_M    <= '0;
              r_Zero <= 1'b1;
            end else begin
              r_R     <= bus.A;
              r_mode  <= bus.Shift_mode;
              r_right <= bus.right;
              r_Zero  <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          if (w_stop) begin
            r_M <= r_R;
          end else begin
            r_R   <= shift_one(r_R, r_mode, r_right);
            r_Cnt <= r_Cnt + BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.M    = r_M;
  assign bus.Cnt  = r_Cnt;
  assign bus.Zero = r_Zero;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_normalizer.sv
module tb_seq_normalizer;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_normalizer_if #(.BITS(8)) bus ();

  seq_normalizer #(.BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start, measure latency (accept edge = cycle 1), check results
  // and that M stays put while shifting and holds after done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic md,
                        input logic rt, input logic [7:0] em, input logic [7:0] ec,
                        input logic ez, input int elat);
    int         lat;
    logic [7:0] m0;
    logic       mchg;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.Shift_mode = md; bus.right = rt;
    m0 = bus.M;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; mchg = 1'b0;
    while (!bus.done && lat < 20) begin
      if (bus.M !== m0) mchg = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},   lat,       elat);
    chk({tag, ".M"},     bus.M,     em);
    chk({tag, ".Cnt"},   bus.Cnt,   ec);
    chk({tag, ".Zero"},  bus.Zero,  ez);
    chk({tag, ".busy"},  bus.busy,  1'b1);
    chk({tag, ".Mhold"}, mchg,      1'b0);
    @(posedge clk); #1;
    chk({tag, ".done_off"}, bus.done, 1'b0);
    chk({tag, ".idle"},     bus.busy, 1'b0);
    chk({tag, ".M_keep"},   bus.M,    em);
    chk({tag, ".C_keep"},   bus.Cnt,  ec);
  endtask

  initial begin
    int lat;
    int dones;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.A = '0; bus.Shift_mode = 1'b0; bus.right = 1'b0;
    #1;
    chk("rst.M",    bus.M,    8'h00);
    chk("rst.Cnt",  bus.Cnt,  8'h00);
    chk("rst.Zero", bus.Zero, 1'b0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    #19;
    rst_n = 1'b1;

    run_op("ll10", 8'h10, 1'b0, 1'b0, 8'h80, 8'd3, 1'b0, 5);
    run_op("laF0", 8'hF0, 1'b1, 1'b0, 8'h80, 8'd3, 1'b0, 5);
    run_op("laFF", 8'hFF, 1'b1, 1'b0, 8'h80, 8'd7, 1'b0, 9);
    run_op("la40", 8'h40, 1'b1, 1'b0, 8'h40, 8'd0, 1'b0, 2);
    run_op("rl28", 8'h28, 1'b0, 1'b1, 8'h05, 8'd3, 1'b0, 5);
    run_op("raA0", 8'hA0, 1'b1, 1'b1, 8'hFD, 8'd5, 1'b0, 7);
    run_op("z_ra", 8'h00, 1'b1, 1'b1, 8'h00, 8'd0, 1'b1, 1);
    run_op("ll80", 8'h80, 1'b0, 1'b0, 8'h80, 8'd0, 1'b0, 2);
    run_op("z_ll", 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1);
    run_op("rl01", 8'h01, 1'b0, 1'b1, 8'h01, 8'd0, 1'b0, 2);
    run_op("ra80", 8'h80, 1'b1, 1'b1, 8'hFF, 8'd7, 1'b0, 9);

    // Start pulsed while busy, and again during the DONE cycle: both ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h01; bus.Shift_mode = 1'b0; bus.right = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.A = 8'h80;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign.lat", lat,     9);
    chk("ign.M",   bus.M,   8'h80);
    chk("ign.Cnt", bus.Cnt, 8'd7);
    bus.start = 1'b1; bus.A = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignD.busy", bus.busy, 1'b0);
    chk("ignD.M",    bus.M,    8'h80);
    chk("ignD.Zero", bus.Zero, 1'b0);
    chk("ignD.Cnt",  bus.Cnt,  8'd7);
    @(posedge clk); #1;
    chk("ignD.busy2", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h01; bus.Shift_mode = 1'b0; bus.right = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre.busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar.M",    bus.M,    8'h00);
    chk("ar.Cnt",  bus.Cnt,  8'h00);
    chk("ar.Zero", bus.Zero, 1'b0);
    chk("ar.busy", bus.busy, 1'b0);
    chk("ar.done", bus.done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("ar.nodone", dones,    0);
    chk("ar.idle",   bus.busy, 1'b0);
    run_op("post", 8'h01, 1'b0, 1'b0, 8'h80, 8'd7, 1'b0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 Parameter BITS, default 8, data and count width; BITS >= 4 SHALL be supported.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request strobe; SHALL be sampled only in IDLE.
REQ-005 A  input  BITS  operand; SHALL be captured on the accepted start edge.
REQ-006 Shift_mode  input  1  1 = arithmetic, 0 = logical; SHALL be captured with A.
REQ-007 right  input  1  1 = normalize rightwards, 0 = leftwards; SHALL be captured with A.
REQ-008 M  output  BITS  normalized operand, registered.
REQ-009 Cnt  output  BITS  number of single-bit shifts applied, registered, unsigned.
REQ-010 Zero  output  1  captured operand was all zeros, registered.
REQ-011 busy  output  1  high in SHIFT and DONE states.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 and A!=0: capture A into working register R, mode and direction into regs, clear Cnt, go to SHIFT.
REQ-015 In IDLE with start=1 and A==0: set M=0, Cnt=0, Zero=1, go directly to DONE.
REQ-016 A start in IDLE SHALL clear Zero when A!=0.
REQ-017 Stop condition, left logical: R[BITS-1]==1.
REQ-018 Stop condition, left arithmetic: R[BITS-1]!=R[BITS-2].
REQ-019 Stop condition, right (either mode): R[0]==1.
REQ-020 In SHIFT, if the stop condition holds: M<=R and go to DONE; otherwise shift R by one bit and Cnt<=Cnt+1.
REQ-021 Shift fill SHALL be: zero on any left shift; zero on right logical; R[BITS-1] (sign) on right arithmetic.
REQ-022 In DONE: done=1 for exactly that cycle, then unconditionally return to IDLE.
REQ-023 Latency from the accepted start edge to done high SHALL be k+2 cycles for nonzero A (k = final Cnt) and 1 cycle for A==0.
REQ-024 Cnt SHALL never exceed BITS-1; overflow of Cnt SHALL be impossible by construction.
REQ-025 start while busy=1 SHALL be ignored with no effect on state or outputs, including start in the DONE cycle.
REQ-026 M, Cnt and Zero SHALL hold their values from done until the next accepted start.
REQ-027 M SHALL not change during SHIFT; it SHALL update only on the DONE transition or the zero path.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, R=0, M=0, Cnt=0, Zero=0, busy=0 and done=0, without waiting for clk.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Verification (BITS=8)
REQ-030 Left logical, A=0x10 -> done at cycle 5, M=0x80, Cnt=3, Zero=0.
REQ-031 Left arithmetic: A=0xF0 -> M=0x80, Cnt=3; A=0xFF -> M=0x80, Cnt=7; A=0x40 -> M=0x40, Cnt=0, done at cycle 2.
REQ-032 Right: logical A=0x28 -> M=0x05, Cnt=3; arithmetic A=0xA0 -> M=0xFD, Cnt=5, done at cycle 7.
REQ-033 A=0x00 in any mode -> done at cycle 1, M=0x00, Cnt=0, Zero=1; a following start with A=0x80 in left logical mode -> Zero=0, Cnt=0.
REQ-034 Start with A=0x01 in left logical mode, pulse start again with A=0x80 at cycle 3 -> the second start is ignored; result M=0x80, Cnt=7, done at cycle 9.
REQ-035 Assert rst_n=0 asynchronously at cycle 3 of an A=0x01 left-logical run -> all outputs 0 before the next clk edge, no done pulse; the next start completes normally.
